// File: rtl/t_ff.sv
// rtl/t_ff.sv - single-bit toggle flop with async active-low clear and preset
module t_ff (
    input  logic clk,
    input  logic cr,
    input  logic pr,
    input  logic t,
    output logic q
);

    localparam logic CLEAR_STATE  = 1'b0;
    localparam logic PRESET_STATE = 1'b1;

    logic r_q;

    // Clear is tested first so it dominates when both async inputs are low.
    always_ff @(posedge clk or negedge cr or negedge pr) begin
        if (!cr) begin
            r_q <= CLEAR_STATE;
        end else if (!pr) begin
            r_q <= PRESET_STATE;
        end else if (t) begin
            r_q <= ~r_q;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/sr_using_t.sv
// rtl/sr_using_t.sv - clocked SR flop built from a T flop and S/R-to-T conversion
module sr_using_t (
    input  logic clk,
    input  logic cr,
    input  logic pr,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_bar
);

    logic w_t;
    logic w_q;

    // Toggle only when the request disagrees with the current state; s=r=1 holds.
    assign w_t = (s & ~r & ~w_q) | (r & ~s & w_q);

    t_ff u_t_ff (
        .clk (clk),
        .cr  (cr),
        .pr  (pr),
        .t   (w_t),
        .q   (w_q)
    );

    assign q     = w_q;
    assign q_bar = ~w_q;

endmodule

// File: tb/tb_sr_using_t.sv
// tb/tb_sr_using_t.sv - directed self-checking bench for sr_using_t
module tb_sr_using_t;

    logic clk;
    logic cr;
    logic pr;
    logic s;
    logic r;
    logic q;
    logic q_bar;

    int n_vec;
    int n_err;

    sr_using_t dut (
        .clk   (clk),
        .cr    (cr),
        .pr    (pr),
        .s     (s),
        .r     (r),
        .q     (q),
        .q_bar (q_bar)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_q(input string tag, input logic exp);
        chk({tag, "_q"}, q, exp);
        chk({tag, "_qbar"}, q_bar, ~exp);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pr = 1'b1;
        cr = 1'b0;
        s  = 1'b0;
        r  = 1'b0;

        #1  chk_q("reset", 1'b0);                    // t=1
        #1  cr = 1'b1;                               // t=2
        #5  chk_q("hold_after_release", 1'b0);       // t=7
        #5  begin s = 1'b0; r = 1'b1; end            // t=12
        #5  chk_q("reset_req", 1'b0);                // t=17
        #5  begin s = 1'b1; r = 1'b0; end            // t=22
        #5  chk_q("set_req", 1'b1);                  // t=27
        #5  begin s = 1'b0; r = 1'b0; end            // t=32
        #5  chk_q("hold_one", 1'b1);                 // t=37
        #5  begin s = 1'b1; r = 1'b1; end            // t=42
        #5  chk_q("both_no_toggle", 1'b1);           // t=47
        #10 chk_q("both_no_toggle_2", 1'b1);         // t=57

        #1  cr = 1'b0;                               // t=58
        #1  chk_q("async_clear", 1'b0);              // t=59
        #1  cr = 1'b1;                               // t=60
        #7  chk_q("clear_release_hold", 1'b0);       // t=67, edge 65 with s=r=1
        #1  pr = 1'b0;                               // t=68
        #1  chk_q("async_preset", 1'b1);             // t=69
        #1  pr = 1'b1;                               // t=70
        #2  begin s = 1'b0; r = 1'b0; end            // t=72
        #5  chk_q("preset_release_hold", 1'b1);      // t=77
        #1  begin pr = 1'b0; cr = 1'b0; end          // t=78
        #1  chk_q("clear_beats_preset", 1'b0);       // t=79
        #1  pr = 1'b1;                               // t=80
        #1  cr = 1'b1;                               // t=81
        #6  chk_q("after_both_release", 1'b0);       // t=87

        #1  begin s = 1'b1; r = 1'b0; end            // t=88
        #9  chk_q("set_again", 1'b1);                // t=97
        #1  begin s = 1'b0; r = 1'b1; end            // t=98
        #9  chk_q("reset_from_one", 1'b0);           // t=107
        #1  begin s = 1'b1; r = 1'b0; pr = 1'b0; end // t=108
        #1  chk_q("preset_mid", 1'b1);               // t=109
        #1  begin s = 1'b0; r = 1'b1; end            // t=110
        #7  chk_q("preset_overrides_clk", 1'b1);     // t=117, edge 115 with r=1
        #1  pr = 1'b1;                               // t=118
        #9  chk_q("reset_after_preset", 1'b0);       // t=127
        #1  begin s = 1'b1; r = 1'b0; end            // t=128
        #9  chk_q("set_from_zero", 1'b1);            // t=137
        #1  begin s = 1'b1; r = 1'b0; end            // t=138
        #9  chk_q("set_when_set", 1'b1);             // t=147

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
